ram_port_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between the instruction-fetch (pc) requester and the ex-stage load/store requester.

---
 rtl/ram_port_arbiter.sv | 111 +++++++++++
 tb/tb_ram_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the fetch (pc) and ex requesters.
// Optional pc starvation guard is built when ARB_STARVE_GUARD_EN is defined.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_req_i,
  input  logic [31:0]       pc_addr_i,
  output logic              pc_gnt_o,
  output logic              pc_rvalid_o,
  output logic [DATA_W-1:0] pc_rdata_o,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  input  logic [31:0]       ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              ex_gnt_o,
  output logic              ex_rvalid_o,
  output logic [DATA_W-1:0] ex_rdata_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic pc_force_c;
  logic pc_win_c;
  logic ex_win_c;
  logic ex_is_write_q;

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt;

  assign pc_force_c = pc_req_i && (starve_cnt == CNT_W'(STARVE_MAX));

  // Run length of denied pc cycles; saturates so the forced win is sticky until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!pc_req_i || pc_win_c) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_starve_cnt;

  assign pc_force_c        = 1'b0;
  assign unused_starve_cnt = '0;
`endif

  // Grant: ex over pc unless the starvation guard forces pc through
  always_comb begin
    ex_win_c = 1'b0;
    pc_win_c = 1'b0;
    if (rst) begin
      ex_win_c = ex_req_i && !pc_force_c;
      pc_win_c = pc_req_i && !ex_win_c;
    end
  end

  assign pc_gnt_o = pc_win_c;
  assign ex_gnt_o = ex_win_c;

  // RAM port is driven straight from the winner in the accept cycle
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (ex_win_c) begin
      mem_ce_o   = 1'b1;
      mem_we_o   = ex_we_i;
      mem_addr_o = ex_addr_i[ADDR_W+1:2];
      if (ex_we_i) begin
        mem_wdata_o = ex_wdata_i;
      end
    end else if (pc_win_c) begin
      mem_ce_o   = 1'b1;
      mem_addr_o = pc_addr_i[ADDR_W+1:2];
    end
  end

  // One-entry response pipe: owner and kind of the access accepted last cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_rvalid_o   <= 1'b0;
      ex_rvalid_o   <= 1'b0;
      ex_is_write_q <= 1'b0;
    end else begin
      pc_rvalid_o   <= pc_win_c;
      ex_rvalid_o   <= ex_win_c;
      ex_is_write_q <= ex_win_c && ex_we_i;
    end
  end

  // RAM read data lands the cycle after the access, so it is steered rather than registered
  assign pc_rdata_o = pc_rvalid_o ? mem_rdata_i : '0;
  assign ex_rdata_o = (ex_rvalid_o && !ex_is_write_q) ? mem_rdata_i : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc_addr_i[31:ADDR_W+2], pc_addr_i[1:0],
                              ex_addr_i[31:ADDR_W+2], ex_addr_i[1:0]};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized scoreboard bench for ram_port_arbiter with a behavioural RAM and arbitration model.
module tb_ram_port_arbiter;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned DEPTH      = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              pc_req_i;
  logic [31:0]       pc_addr_i;
  logic              pc_gnt_o;
  logic              pc_rvalid_o;
  logic [DATA_W-1:0] pc_rdata_o;
  logic              ex_req_i;
  logic              ex_we_i;
  logic [31:0]       ex_addr_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              ex_gnt_o;
  logic              ex_rvalid_o;
  logic [DATA_W-1:0] ex_rdata_o;
  logic              mem_ce_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .pc_req_i(pc_req_i), .pc_addr_i(pc_addr_i), .pc_gnt_o(pc_gnt_o),
    .pc_rvalid_o(pc_rvalid_o), .pc_rdata_o(pc_rdata_o),
    .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
    .ex_gnt_o(ex_gnt_o), .ex_rvalid_o(ex_rvalid_o), .ex_rdata_o(ex_rdata_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Behavioural single-port synchronous RAM
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_ce_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i     <= ram[mem_addr_o];
    end
  end

  typedef struct {
    time               due;
    bit                ex;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] shadow [DEPTH];
  int                streak;
  int                tests;
  int                fails;
  bit                pc_granted_seen;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endfunction

  // One bus cycle: drive after the edge, then check grant and RAM port against the model
  task automatic step(input bit r, input bit pr, input logic [31:0] pa,
                      input bit er, input bit ew, input logic [31:0] ea, input logic [DATA_W-1:0] ed);
    bit                pc_w;
    bit                ex_w;
    bit                force_pc;
    logic [ADDR_W-1:0] pw;
    logic [ADDR_W-1:0] ew_idx;
    logic [45:0]       mem_exp;
    exp_t              e;
    @(posedge clk);
    #1;
    rst = r; pc_req_i = pr; pc_addr_i = pa;
    ex_req_i = er; ex_we_i = ew; ex_addr_i = ea; ex_wdata_i = ed;
    #1;
    pw      = pa[ADDR_W+1:2];
    ew_idx  = ea[ADDR_W+1:2];
    pc_w    = 1'b0;
    ex_w    = 1'b0;
    mem_exp = '0;
    if (!r) begin
      sb.delete();
      streak = 0;
    end else begin
`ifdef ARB_STARVE_GUARD_EN
      force_pc = pr && (streak == int'(STARVE_MAX));
`else
      force_pc = 1'b0;
`endif
      ex_w = er && !force_pc;
      pc_w = pr && !ex_w;
      if (pr && !pc_w) streak = (streak < int'(STARVE_MAX)) ? streak + 1 : streak;
      else             streak = 0;
      e.due = $time + 13;
      if (ex_w) begin
        e.ex = 1'b1;
        if (ew) begin
          mem_exp = {1'b1, 1'b1, ew_idx, ed};
          shadow[ew_idx] = ed;
          e.data = '0;
        end else begin
          mem_exp = {1'b1, 1'b0, ew_idx, {DATA_W{1'b0}}};
          e.data = shadow[ew_idx];
        end
        sb.push_back(e);
      end else if (pc_w) begin
        mem_exp = {1'b1, 1'b0, pw, {DATA_W{1'b0}}};
        e.ex   = 1'b0;
        e.data = shadow[pw];
        sb.push_back(e);
      end
    end
    if (pc_gnt_o) pc_granted_seen = 1'b1;
    chk("grant", 128'({pc_gnt_o, ex_gnt_o}), 128'({pc_w, ex_w}));
    chk("mem_port", 128'({mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o}), 128'(mem_exp));
  endtask

  // Monitor: pop the due response each negedge and compare both response ports
  initial begin
    exp_t              e;
    logic [65:0]       want;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due < $time) begin
        e = sb.pop_front();
        tests++;
        fails++;
        $display("FAIL resp_missing at %0t: got none expected response due %0t", $time, e.due);
      end
      want = '0;
      if (sb.size() > 0 && sb[0].due == $time) begin
        e = sb.pop_front();
        if (e.ex) want = {1'b0, {DATA_W{1'b0}}, 1'b1, e.data};
        else      want = {1'b1, e.data, 1'b0, {DATA_W{1'b0}}};
      end
      chk("response", 128'({pc_rvalid_o, pc_rdata_o, ex_rvalid_o, ex_rdata_o}), 128'(want));
    end
  end

  initial begin
    tests = 0; fails = 0; streak = 0; pc_granted_seen = 1'b0;
    rst = 1'b0; pc_req_i = 1'b0; pc_addr_i = '0; ex_req_i = 1'b0;
    ex_we_i = 1'b0; ex_addr_i = '0; ex_wdata_i = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i]    = DATA_W'($urandom);
      shadow[i] = ram[i];
    end
    ram[5]    = 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;

    // Reset with both requesting, then release
    step(1'b0, 1'b1, 32'h14, 1'b1, 1'b0, 32'h40, '0);
    step(1'b0, 1'b1, 32'h14, 1'b1, 1'b0, 32'h40, '0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, '0);
    // pc read of word 5
    step(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, '0);
    // ex write then back-to-back read of the same word
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, '0);
    // Contention for 3 cycles, then ex drops
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 32'h40, '0);
    step(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, '0);
    // Continuous ex traffic against a waiting pc
    pc_granted_seen = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 32'h18, 1'b1, 1'b0, 32'h44 + 32'(4 * i), '0);
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_pc_won", 128'(pc_granted_seen), 128'(1));
`else
    chk("starve_pc_won", 128'(pc_granted_seen), 128'(0));
`endif
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    // Reset during the response cycle of a pc read
    step(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, '0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);

    // Random traffic over a small address window to provoke read-after-write hits
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] pa;
      logic [31:0] ea;
      pa = {$urandom_range(0, 15), 4'($urandom_range(0, 15)), 2'($urandom)} & 32'hFFFF_003F;
      pa = {18'($urandom), pa[13:0]} & 32'hFFFC_003F | {16'h0, 16'h0} | (pa & 32'h3);
      ea = {18'($urandom), 8'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      pa = {18'($urandom), 8'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), pa,
           ($urandom_range(0, 2) != 0), 1'($urandom), ea, DATA_W'($urandom));
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
